// File: rtl/pspin_her_gen_mc.sv
// rtl/pspin_her_gen_mc.sv - multi-channel credit-managed HER generator with round-robin arbitration
// Optional per-context issued-HER counters: define PSPIN_HER_GEN_MC_STATS_EN.
module pspin_her_gen_mc #(
    parameter int NUM_CHANNELS    = 2,
    parameter int NUM_HANDLER_CTX = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 32,
    parameter int TAG_WIDTH       = 32,
    parameter int MSG_ID_WIDTH    = 10,
    parameter int CREDITS_PER_CTX = 16,
    parameter int CTX_W           = (NUM_HANDLER_CTX > 1) ? $clog2(NUM_HANDLER_CTX) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] gen_addr,
    input  logic [NUM_CHANNELS*LEN_WIDTH-1:0]  gen_len,
    input  logic [NUM_CHANNELS*TAG_WIDTH-1:0]  gen_tag,
    input  logic [NUM_CHANNELS-1:0]            gen_valid,
    output logic [NUM_CHANNELS-1:0]            gen_ready,
    input  logic [NUM_HANDLER_CTX-1:0]         conf_ctx_enabled,
    input  logic                               conf_valid,
    output logic                               her_valid,
    input  logic                               her_ready,
    output logic [MSG_ID_WIDTH-1:0]            her_msgid,
    output logic                               her_is_eom,
    output logic [CTX_W-1:0]                   her_ctx_id,
    output logic [ADDR_WIDTH-1:0]              her_addr,
    output logic [LEN_WIDTH-1:0]               her_size,
    output logic [LEN_WIDTH-1:0]               her_xfer_size,
    input  logic                               feedback_valid,
    input  logic [CTX_W-1:0]                   feedback_ctx_id,
    output logic [31:0]                        dropped_pkts,
    output logic                               credit_overflow,
    output logic [NUM_HANDLER_CTX*32-1:0]      issued_cnt
);
    localparam int CTX_N  = 1 << CTX_W;
    localparam int CRED_W = $clog2(CREDITS_PER_CTX + 1);
    localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS_PER_CTX);

    // Context tables are padded to the full CTX_W range so out-of-range ids index safely;
    // padded enables stay 0, which makes those ids drop.
    logic [CTX_N-1:0]  enables;
    logic [CRED_W-1:0] credits [CTX_N];
    logic [CH_W-1:0]   rr_ptr;

    logic [CTX_W-1:0]        ch_ctx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ch_drop;
    logic [NUM_CHANNELS-1:0] elig;
    logic [NUM_CHANNELS-1:0] grant;
    logic                    found;
    logic [CH_W-1:0]         gidx;
    logic                    slot_free;
    logic                    do_issue;
    logic                    do_drop;
    logic [TAG_WIDTH-1:0]    sel_tag;
    logic [LEN_WIDTH-1:0]    sel_len;
    logic [LEN_WIDTH:0]      len_sum;
    logic [LEN_WIDTH-1:0]    sel_xfer;
    logic [CTX_N-1:0]        dec;
    logic [CTX_N-1:0]        fb_ok;
    logic                    fb_in_range;
    logic                    overflow_evt;

    assign slot_free = !her_valid || her_ready;

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ch_ctx[i]  = gen_tag[i*TAG_WIDTH + MSG_ID_WIDTH + 1 +: CTX_W];
            ch_drop[i] = !enables[ch_ctx[i]];
            elig[i]    = !rst && gen_valid[i] &&
                         (ch_drop[i] || (credits[ch_ctx[i]] != '0 && slot_free));
        end
    end

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                gidx  = CH_W'(idx);
            end
        end
        grant = '0;
        if (found) grant[gidx] = 1'b1;
    end

    assign gen_ready = grant;
    assign do_issue  = found && !ch_drop[gidx];
    assign do_drop   = found && ch_drop[gidx];
    assign sel_tag   = gen_tag[gidx*TAG_WIDTH +: TAG_WIDTH];
    assign sel_len   = gen_len[gidx*LEN_WIDTH +: LEN_WIDTH];

    // Round up to a 64 B transfer; a carry out means the rounded size would not fit.
    assign len_sum  = {1'b0, sel_len} + (LEN_WIDTH+1)'(63);
    assign sel_xfer = len_sum[LEN_WIDTH] ? ({LEN_WIDTH{1'b1}} & ~LEN_WIDTH'(63))
                                         : (len_sum[LEN_WIDTH-1:0] & ~LEN_WIDTH'(63));

    assign fb_in_range = int'(feedback_ctx_id) < NUM_HANDLER_CTX;

    always_comb begin
        for (int c = 0; c < CTX_N; c++) begin
            dec[c]   = do_issue && (ch_ctx[gidx] == CTX_W'(c));
            fb_ok[c] = feedback_valid && fb_in_range && (feedback_ctx_id == CTX_W'(c)) &&
                       ((credits[c] != CRED_MAX) || dec[c]);
        end
        overflow_evt = feedback_valid &&
                       (!fb_in_range ||
                        ((credits[feedback_ctx_id] == CRED_MAX) && !dec[feedback_ctx_id]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            her_valid       <= 1'b0;
            her_msgid       <= '0;
            her_is_eom      <= 1'b0;
            her_ctx_id      <= '0;
            her_addr        <= '0;
            her_size        <= '0;
            her_xfer_size   <= '0;
            enables         <= '0;
            rr_ptr          <= '0;
            dropped_pkts    <= '0;
            credit_overflow <= 1'b0;
            for (int c = 0; c < CTX_N; c++) credits[c] <= CRED_MAX;
        end else begin
            if (her_valid && her_ready) her_valid <= 1'b0;
            if (do_issue) begin
                her_valid     <= 1'b1;
                her_msgid     <= sel_tag[MSG_ID_WIDTH-1:0];
                her_is_eom    <= sel_tag[MSG_ID_WIDTH];
                her_ctx_id    <= ch_ctx[gidx];
                her_addr      <= gen_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
                her_size      <= sel_len;
                her_xfer_size <= sel_xfer;
            end
            if (found) rr_ptr <= (int'(gidx) == NUM_CHANNELS - 1) ? '0 : gidx + 1'b1;
            if (do_drop && dropped_pkts != 32'hFFFF_FFFF) dropped_pkts <= dropped_pkts + 32'd1;
            if (overflow_evt) credit_overflow <= 1'b1;
            for (int c = 0; c < CTX_N; c++) begin
                if (dec[c] && !fb_ok[c])      credits[c] <= credits[c] - 1'b1;
                else if (fb_ok[c] && !dec[c]) credits[c] <= credits[c] + 1'b1;
            end
            // Reload on enable overrides any same-cycle credit movement.
            if (conf_valid) begin
                enables <= CTX_N'(conf_ctx_enabled);
                for (int c = 0; c < NUM_HANDLER_CTX; c++)
                    if (conf_ctx_enabled[c] && !enables[c]) credits[c] <= CRED_MAX;
            end
        end
    end

`ifdef PSPIN_HER_GEN_MC_STATS_EN
    logic [31:0] cnt [NUM_HANDLER_CTX];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_HANDLER_CTX; c++) cnt[c] <= '0;
        end else if (her_valid && her_ready) begin
            for (int c = 0; c < NUM_HANDLER_CTX; c++)
                if (her_ctx_id == CTX_W'(c)) cnt[c] <= cnt[c] + 32'd1;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_HANDLER_CTX; c++) issued_cnt[c*32 +: 32] = cnt[c];
    end
`else
    assign issued_cnt = '0;
`endif

endmodule

// File: tb/tb_pspin_her_gen_mc.sv
// tb/tb_pspin_her_gen_mc.sv - scoreboard bench for pspin_her_gen_mc (2 channels, 3 contexts, 2 credits)
module tb_pspin_her_gen_mc;
    localparam int NC = 2, NH = 3, CPC = 2, CW = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic [63:0] gen_addr = '0, gen_len = '0, gen_tag = '0;
    logic [1:0]  gen_valid = '0, gen_ready;
    logic [2:0]  conf_ctx_enabled = '0;
    logic        conf_valid = 1'b0, her_valid, her_ready = 1'b1, her_is_eom;
    logic [9:0]  her_msgid;
    logic [1:0]  her_ctx_id, feedback_ctx_id = '0;
    logic [31:0] her_addr, her_size, her_xfer_size, dropped_pkts;
    logic        feedback_valid = 1'b0, credit_overflow;
    logic [95:0] issued_cnt;

    typedef struct {
        logic [31:0] addr, len, xfer;
        logic [9:0]  msgid;
        logic        eom;
        logic [1:0]  ctx;
    } her_t;

    her_t        exp_q[$];
    int          n_assert = 0, n_fail = 0, exp_drop = 0;
    logic [2:0]  en_model = '0;
    logic [31:0] cnt_model [NH];

    pspin_her_gen_mc #(.NUM_CHANNELS(NC), .NUM_HANDLER_CTX(NH), .CREDITS_PER_CTX(CPC)) dut (
        .clk(clk), .rst(rst), .gen_addr(gen_addr), .gen_len(gen_len), .gen_tag(gen_tag),
        .gen_valid(gen_valid), .gen_ready(gen_ready), .conf_ctx_enabled(conf_ctx_enabled),
        .conf_valid(conf_valid), .her_valid(her_valid), .her_ready(her_ready),
        .her_msgid(her_msgid), .her_is_eom(her_is_eom), .her_ctx_id(her_ctx_id),
        .her_addr(her_addr), .her_size(her_size), .her_xfer_size(her_xfer_size),
        .feedback_valid(feedback_valid), .feedback_ctx_id(feedback_ctx_id),
        .dropped_pkts(dropped_pkts), .credit_overflow(credit_overflow), .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish before 400us");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] round64(input logic [31:0] len);
        longint r;
        r = ((longint'(len) + 63) / 64) * 64;
        return (r > 64'hFFFF_FFFF) ? 32'hFFFF_FFC0 : r[31:0];
    endfunction

    always @(negedge clk) begin
        if (!rst && her_valid && her_ready) begin
            her_t e;
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL her_unexpected: got addr=%h ctx=%0d, required no HER", her_addr, her_ctx_id);
            end else begin
                e = exp_q.pop_front();
                cnt_model[e.ctx]++;
                if ({her_addr, her_size, her_xfer_size, her_msgid, her_is_eom, her_ctx_id} !==
                    {e.addr, e.len, e.xfer, e.msgid, e.eom, e.ctx}) begin
                    n_fail++;
                    $display("FAIL her_fields: got addr=%h size=%h xfer=%h msgid=%h eom=%b ctx=%0d, required addr=%h size=%h xfer=%h msgid=%h eom=%b ctx=%0d",
                             her_addr, her_size, her_xfer_size, her_msgid, her_is_eom, her_ctx_id,
                             e.addr, e.len, e.xfer, e.msgid, e.eom, e.ctx);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] addr, input logic [31:0] len,
                          input int ctx, input logic eom, input logic [9:0] msgid);
        logic [31:0] t;
        t = '0;
        t[9:0]   = msgid;
        t[10]    = eom;
        t[12:11] = ctx[1:0];
        gen_addr[ch*32 +: 32] = addr;
        gen_len[ch*32 +: 32]  = len;
        gen_tag[ch*32 +: 32]  = t;
    endtask

    task automatic on_grant(input int ch);
        her_t e;
        int   ctx;
        ctx = int'(gen_tag[ch*32 + 11 +: 2]);
        if (ctx < NH && en_model[ctx]) begin
            e.addr  = gen_addr[ch*32 +: 32];
            e.len   = gen_len[ch*32 +: 32];
            e.xfer  = round64(e.len);
            e.msgid = gen_tag[ch*32 +: 10];
            e.eom   = gen_tag[ch*32 + 10];
            e.ctx   = ctx[1:0];
            exp_q.push_back(e);
        end else begin
            exp_drop++;
        end
    endtask

    task automatic send(input int ch, input logic [31:0] addr, input logic [31:0] len,
                        input int ctx, input logic eom, input logic [9:0] msgid,
                        input int max_wait, output bit granted);
        set_ch(ch, addr, len, ctx, eom, msgid);
        gen_valid[ch] = 1'b1;
        granted = 0;
        for (int k = 0; k < max_wait && !granted; k++) begin
            @(negedge clk);
            if (gen_ready[ch]) begin
                granted = 1;
                on_grant(ch);
            end
            step();
        end
        gen_valid[ch] = 1'b0;
    endtask

    task automatic configure(input logic [2:0] en);
        conf_ctx_enabled = en;
        conf_valid = 1'b1;
        step();
        conf_valid = 1'b0;
        en_model = en;
    endtask

    task automatic feedback(input int ctx);
        feedback_valid = 1'b1;
        feedback_ctx_id = ctx[1:0];
        step();
        feedback_valid = 1'b0;
    endtask

    task automatic check_granted(input string name, input bit got, input bit req);
        n_assert++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: granted=%0d, required %0d", name, got, req);
        end
    endtask

    task automatic check_ready(input string name, input logic [1:0] req);
        @(negedge clk);
        n_assert++;
        if (gen_ready !== req) begin
            n_fail++;
            $display("FAIL %s: gen_ready=%b, required %b", name, gen_ready, req);
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < NH; c++) cnt_model[c] = '0;
        rst = 1'b1;
        set_ch(0, 32'h1000, 32'd10, 0, 1'b0, 10'd1);
        set_ch(1, 32'h2000, 32'd10, 2, 1'b0, 10'd2);
        gen_valid = 2'b11;
        step();
        @(negedge clk);
        n_assert++;
        if ({her_valid, gen_ready, dropped_pkts, credit_overflow, her_addr, her_xfer_size, her_ctx_id, issued_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: her_valid=%b gen_ready=%b dropped=%0d ovf=%b addr=%h xfer=%h issued=%h, required all zero",
                     her_valid, gen_ready, dropped_pkts, credit_overflow, her_addr, her_xfer_size, issued_cnt);
        end
        step();
        gen_valid = 2'b00;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        bit g;
        configure(3'b011);
        send(0, 32'h1C10_0000, 32'd100, 0, 1'b1, 10'd5, 4, g);
        check_granted("single_grant", g, 1);
        @(negedge clk);
        n_assert++;
        if (her_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: her_valid=%b one cycle after grant, required 1", her_valid);
        end
        step();
        feedback(0);
    endtask

    // Pointer sits at 1 after the single ch0 grant, so ch1 wins first.
    task automatic test_round_robin();
        logic [1:0] order [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        set_ch(0, 32'hA000_0000, 32'd64, 0, 1'b0, 10'd10);
        set_ch(1, 32'hB000_0000, 32'd65, 1, 1'b1, 10'd20);
        gen_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            check_ready($sformatf("rr_grant%0d", k), order[k]);
            if (gen_ready[0]) on_grant(0);
            if (gen_ready[1]) on_grant(1);
            step();
            if (order[k][0]) gen_addr[31:0]  = gen_addr[31:0] + 32'h40;
            if (order[k][1]) gen_addr[63:32] = gen_addr[63:32] + 32'h40;
        end
        check_ready("rr_credit_exhausted", 2'b00);
        step();
        gen_valid = 2'b00;
        step();
    endtask

    task automatic test_credit_stall();
        set_ch(1, 32'hC000_0000, 32'd200, 1, 1'b0, 10'd30);
        set_ch(0, 32'hD000_0000, 32'd8, 2, 1'b0, 10'd31);
        gen_valid = 2'b11;
        check_ready("no_hol_drop_passes", 2'b01);
        on_grant(0);
        step();
        gen_valid = 2'b10;
        check_ready("stall_zero_credit", 2'b00);
        step();
        feedback_valid = 1'b1;
        feedback_ctx_id = 2'd1;
        check_ready("stall_during_feedback", 2'b00);
        step();
        feedback_valid = 1'b0;
        check_ready("issue_after_feedback", 2'b10);
        on_grant(1);
        step();
        gen_valid = 2'b00;
        step();
    endtask

    task automatic test_drop();
        bit g0, g1;
        fork
            send(0, 32'hE000_0000, 32'd40, 2, 1'b1, 10'd40, 4, g0);
            send(1, 32'hF000_0000, 32'd40, 3, 1'b1, 10'd41, 4, g1);
        join
        check_granted("drop_disabled_ctx", g0, 1);
        check_granted("drop_out_of_range_ctx", g1, 1);
        @(negedge clk);
        n_assert++;
        if (dropped_pkts !== 32'(exp_drop) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drop_count: dropped_pkts=%0d pending=%0d, required %0d and 0",
                     dropped_pkts, exp_q.size(), exp_drop);
        end
        step();
    endtask

    task automatic test_same_cycle();
        feedback(0);
        set_ch(0, 32'h3000_0000, 32'd1, 0, 1'b0, 10'd50);
        gen_valid = 2'b01;
        feedback_valid = 1'b1;
        feedback_ctx_id = 2'd0;
        check_ready("same_cycle_issue", 2'b01);
        on_grant(0);
        step();
        feedback_valid = 1'b0;
        gen_addr[31:0] = 32'h3000_0040;
        check_ready("credit_unchanged_issue", 2'b01);
        on_grant(0);
        step();
        gen_addr[31:0] = 32'h3000_0080;
        check_ready("credit_now_zero", 2'b00);
        step();
        gen_valid = 2'b00;
        step();
    endtask

    task automatic test_xfer_and_reload();
        bit g;
        configure(3'b000);
        configure(3'b011);
        send(0, 32'h4000_0000, 32'hFFFF_FFF0, 1, 1'b0, 10'h3FF, 4, g);
        check_granted("xfer_saturate", g, 1);
        send(1, 32'h4000_1000, 32'd64, 0, 1'b1, 10'd60, 4, g);
        check_granted("xfer_exact64", g, 1);
        send(0, 32'h4000_2000, 32'd0, 0, 1'b0, 10'd61, 4, g);
        check_granted("xfer_zero_reloaded", g, 1);
        send(1, 32'h4000_3000, 32'd65, 1, 1'b1, 10'd62, 4, g);
        check_granted("xfer_65", g, 1);
        step();
    endtask

    task automatic test_overflow();
        feedback(1);
        feedback(1);
        @(negedge clk);
        n_assert++;
        if (credit_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_early: credit_overflow=%b, required 0", credit_overflow);
        end
        step();
        feedback(1);
        @(negedge clk);
        n_assert++;
        if (credit_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: credit_overflow=%b, required 1", credit_overflow);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit g;
        logic [31:0] held;
        her_ready = 1'b0;
        send(0, 32'h5000_0000, 32'd128, 1, 1'b1, 10'd70, 4, g);
        check_granted("mid_grant", g, 1);
        step();
        held = her_addr;
        @(negedge clk);
        n_assert++;
        if (her_valid !== 1'b1 || her_addr !== 32'h5000_0000 || held !== 32'h5000_0000) begin
            n_fail++;
            $display("FAIL her_hold: her_valid=%b addr=%h, required 1 and 50000000", her_valid, her_addr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        en_model = '0;
        exp_drop = 0;
        for (int c = 0; c < NH; c++) cnt_model[c] = '0;
        @(negedge clk);
        n_assert++;
        if (her_valid !== 1'b0 || dropped_pkts !== 32'd0 || credit_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: her_valid=%b dropped=%0d ovf=%b, required 0 0 0",
                     her_valid, dropped_pkts, credit_overflow);
        end
        step();
        her_ready = 1'b1;
        send(0, 32'h6000_0000, 32'd4, 0, 1'b0, 10'd80, 4, g);
        check_granted("enables_cleared_drop", g, 1);
        @(negedge clk);
        n_assert++;
        if (dropped_pkts !== 32'd1 || her_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL enables_cleared: dropped=%0d her_valid=%b, required 1 and 0", dropped_pkts, her_valid);
        end
        step();
    endtask

    task automatic test_final();
        logic [95:0] exp_cnt;
`ifdef PSPIN_HER_GEN_MC_STATS_EN
        exp_cnt = {cnt_model[2], cnt_model[1], cnt_model[0]};
`else
        exp_cnt = '0;
`endif
        repeat (3) step();
        @(negedge clk);
        n_assert++;
        if (exp_q.size() != 0 || issued_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL final_state: pending=%0d issued=%h, required 0 and %h", exp_q.size(), issued_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_credit_stall();
        test_drop();
        test_same_cycle();
        test_xfer_and_reload();
        test_overflow();
        test_reset_mid();
        test_final();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
